// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcodes (common with the ALU),
// FSM state encoding and instruction field positions.
package alu_sequencer_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_DIV  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_MUL  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int SRCA_MSB = 11;
  localparam int SRCA_LSB = 8;
  localparam int SRCB_MSB = 7;
  localparam int SRCB_LSB = 4;
  localparam int DEST_MSB = 3;
  localparam int DEST_LSB = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_IF,
    S_ID,
    S_RA,
    S_RB,
    S_EX,
    S_WB1,
    S_WB2,
    S_HALT
  } state_t;

endpackage

// File: rtl/alu_sequencer_instr_decode.sv
// Combinational instruction splitter: extracts the four fields and classifies
// the opcode as valid, two-result (MUL/DIV), NOP or HALT.
module instr_decode
  import alu_sequencer_pkg::*;
(
  input  logic [15:0] instr,
  output logic [3:0]  opcode,
  output logic [3:0]  src_a,
  output logic [3:0]  src_b,
  output logic [3:0]  dest,
  output logic        is_valid,
  output logic        is_nop,
  output logic        is_two_result,
  output logic        is_halt
);

  assign opcode = instr[OPC_MSB:OPC_LSB];
  assign src_a  = instr[SRCA_MSB:SRCA_LSB];
  assign src_b  = instr[SRCB_MSB:SRCB_LSB];
  assign dest   = instr[DEST_MSB:DEST_LSB];

  always_comb begin
    is_valid      = 1'b0;
    is_nop        = 1'b0;
    is_two_result = 1'b0;
    is_halt       = 1'b0;
    case (opcode)
      OP_NOP: begin
        is_valid = 1'b1;
        is_nop   = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        is_valid = 1'b1;
      end
      OP_MUL, OP_DIV: begin
        is_valid      = 1'b1;
        is_two_result = 1'b1;
      end
      OP_HALT: begin
        is_valid = 1'b1;
        is_halt  = 1'b1;
      end
      default: begin
        is_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/operand-load controller feeding the 8-bit ALU; reads two
// operands from data memory, issues one ALU op and writes the result(s) back.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err_illegal,
  output logic            err_div0,
  output logic [PC_W-1:0] im_addr,
  output logic            im_re,
  input  logic [15:0]     im_rdata,
  output logic [3:0]      dm_addr,
  output logic            dm_re,
  output logic            dm_we,
  output logic [7:0]      dm_wdata,
  input  logic [7:0]      dm_rdata,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [3:0]      alu_sel,
  input  logic [7:0]      alu_res1,
  input  logic [7:0]      alu_res2
);

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc;
  logic [15:0]     instr_q;
  logic [7:0]      op_a;
  logic [7:0]      op_b;
  logic            err_illegal_q;
  logic            err_div0_q;
  logic            armed;

  logic [15:0]     cur_instr;
  logic [3:0]      dec_opcode;
  logic [3:0]      dec_src_a;
  logic [3:0]      dec_src_b;
  logic [3:0]      dec_dest;
  logic            dec_valid;
  logic            dec_nop;
  logic            dec_two_result;
  logic            dec_halt;
  logic            start_ok;
  logic            div_zero;

  // In ID the fresh memory word is decoded directly; afterwards the latched copy.
  assign cur_instr = (state == S_ID) ? im_rdata : instr_q;

  instr_decode u_decode (
    .instr         (cur_instr),
    .opcode        (dec_opcode),
    .src_a         (dec_src_a),
    .src_b         (dec_src_b),
    .dest          (dec_dest),
    .is_valid      (dec_valid),
    .is_nop        (dec_nop),
    .is_two_result (dec_two_result),
    .is_halt       (dec_halt)
  );

  // armed stays low for the first edge after reset so a coincident start is dropped.
  assign start_ok = start && armed && ((state == S_IDLE) || (state == S_HALT));
  assign div_zero = (dec_opcode == OP_DIV) && (dm_rdata == 8'h00);

  assign busy        = (state != S_IDLE) && (state != S_HALT);
  assign done        = (state == S_HALT);
  assign err_illegal = err_illegal_q;
  assign err_div0    = err_div0_q;
  assign alu_a       = op_a;
  assign alu_b       = op_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    im_addr   = '0;
    im_re     = 1'b0;
    dm_addr   = 4'h0;
    dm_re     = 1'b0;
    dm_we     = 1'b0;
    dm_wdata  = 8'h00;
    alu_sel   = OP_NOP;
    case (state)
      S_IDLE, S_HALT: begin
        if (start_ok) begin
          state_nxt = S_IF;
        end
      end
      S_IF: begin
        im_addr   = pc;
        im_re     = 1'b1;
        state_nxt = S_ID;
      end
      S_ID: begin
        if (dec_halt) begin
          state_nxt = S_HALT;
        end else if (dec_nop || !dec_valid) begin
          state_nxt = S_IF;
        end else begin
          dm_addr   = dec_src_a;
          dm_re     = 1'b1;
          state_nxt = S_RA;
        end
      end
      S_RA: begin
        dm_addr   = dec_src_b;
        dm_re     = 1'b1;
        state_nxt = S_RB;
      end
      S_RB: begin
        state_nxt = div_zero ? S_IF : S_EX;
      end
      S_EX: begin
        alu_sel   = dec_opcode;
        state_nxt = S_WB1;
      end
      S_WB1: begin
        dm_addr   = dec_dest;
        dm_we     = 1'b1;
        dm_wdata  = alu_res1;
        state_nxt = dec_two_result ? S_WB2 : S_IF;
      end
      S_WB2: begin
        dm_addr   = dec_dest + 4'd1;
        dm_we     = 1'b1;
        dm_wdata  = alu_res2;
        state_nxt = S_IF;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= '0;
      instr_q       <= 16'h0000;
      op_a          <= 8'h00;
      op_b          <= 8'h00;
      err_illegal_q <= 1'b0;
      err_div0_q    <= 1'b0;
      armed         <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE, S_HALT: begin
          if (start_ok) begin
            pc            <= '0;
            err_illegal_q <= 1'b0;
            err_div0_q    <= 1'b0;
          end
        end
        S_ID: begin
          instr_q <= im_rdata;
          pc      <= pc + PC_W'(1);
          if (!dec_valid) begin
            err_illegal_q <= 1'b1;
          end
        end
        S_RA: begin
          op_a <= dm_rdata;
        end
        S_RB: begin
          op_b <= dm_rdata;
          if (div_zero) begin
            err_div0_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: instruction/data memories and an ALU around the sequencer,
// an ISA-level reference model, and a per-cycle compare of every bus access.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int PC_W     = 4;
  localparam int IM_DEPTH = 1 << PC_W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            busy, done, err_illegal, err_div0;
  logic [PC_W-1:0] im_addr;
  logic            im_re;
  logic [15:0]     im_rdata = 16'h0000;
  logic [3:0]      dm_addr;
  logic            dm_re, dm_we;
  logic [7:0]      dm_wdata;
  logic [7:0]      dm_rdata = 8'h00;
  logic [7:0]      alu_a, alu_b;
  logic [3:0]      alu_sel;
  logic [7:0]      alu_res1 = 8'h00;
  logic [7:0]      alu_res2 = 8'h00;

  logic [15:0] imem [IM_DEPTH];
  logic [7:0]  dmem [16];
  logic [7:0]  dmem_init [16];
  logic        load_req = 1'b0;

  typedef struct packed { logic we; logic [3:0] addr; logic [7:0] data; } dm_ev_t;
  typedef struct packed { logic [3:0] op; logic [7:0] a; logic [7:0] b; } alu_ev_t;

  dm_ev_t  exp_dm [$];
  alu_ev_t exp_alu [$];
  int      exp_fetch [$];
  logic [7:0] mdmem [16];
  int      m_cycles;
  logic    m_err_ill, m_err_div0;

  int total = 0;
  int bad = 0;
  int alu_cycles = 0;
  int we_cycles = 0;

  logic [3:0] op_tbl [9] = '{4'h0, 4'h3, 4'h6, 4'h7, 4'h4, 4'h4, 4'h7, 4'h3, 4'h6};
  logic [3:0] ill_tbl [10] = '{4'h1, 4'h2, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};

  always #5 clk = ~clk;

  alu_sequencer #(.PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .err_illegal(err_illegal), .err_div0(err_div0),
    .im_addr(im_addr), .im_re(im_re), .im_rdata(im_rdata),
    .dm_addr(dm_addr), .dm_re(dm_re), .dm_we(dm_we), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res1(alu_res1), .alu_res2(alu_res2)
  );

  // Synchronous memories and the ALU the sequencer talks to
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 16; i++) dmem[i] <= dmem_init[i];
    end else begin
      if (dm_re) dm_rdata <= dmem[dm_addr];
      if (dm_we) dmem[dm_addr] <= dm_wdata;
    end
    if (im_re) im_rdata <= imem[im_addr];
    case (alu_sel)
      OP_ADD: {alu_res2, alu_res1} <= {8'h00, alu_a} + {8'h00, alu_b};
      OP_SUB: {alu_res2, alu_res1} <= {8'h00, alu_a - alu_b};
      OP_MUL: {alu_res2, alu_res1} <= {8'h00, alu_a} * {8'h00, alu_b};
      OP_DIV: if (alu_b != 8'h00) {alu_res2, alu_res1} <= {alu_a % alu_b, alu_a / alu_b};
      default: ;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Every cycle: each fetch, memory access and ALU issue must be the next one the model predicts
  task automatic cycleCompare();
    dm_ev_t  e;
    alu_ev_t a;
    checkOutput("re_we_exclusive", 32'(dm_re & dm_we), 32'd0);
    checkOutput("busy_done_exclusive", 32'(busy & done), 32'd0);
    if (im_re) begin
      checkOutput("fetch_expected", 32'(exp_fetch.size() > 0), 32'd1);
      if (exp_fetch.size() > 0) checkOutput("fetch_addr", 32'(im_addr), 32'(exp_fetch.pop_front()));
    end
    if (dm_re || dm_we) begin
      if (dm_we) we_cycles++;
      checkOutput("dm_expected", 32'(exp_dm.size() > 0), 32'd1);
      if (exp_dm.size() > 0) begin
        e = exp_dm.pop_front();
        checkOutput("dm_kind_we", 32'(dm_we), 32'(e.we));
        checkOutput("dm_addr", 32'(dm_addr), 32'(e.addr));
        if (dm_we) checkOutput("dm_wdata", 32'(dm_wdata), 32'(e.data));
      end
    end
    if (alu_sel != 4'h0) begin
      alu_cycles++;
      checkOutput("alu_expected", 32'(exp_alu.size() > 0), 32'd1);
      if (exp_alu.size() > 0) begin
        a = exp_alu.pop_front();
        checkOutput("alu_sel", 32'(alu_sel), 32'(a.op));
        checkOutput("alu_a", 32'(alu_a), 32'(a.a));
        checkOutput("alu_b", 32'(alu_b), 32'(a.b));
      end
    end
  endtask

  task automatic waitCycle();
    @(negedge clk);
    cycleCompare();
  endtask

  // ISA-level interpreter: architectural effects plus the cycle cost of each instruction
  task automatic runModel(input bit patch_wrap);
    int pc, ia, ib, r1, r2;
    bit wrapped;
    logic [15:0] ins;
    logic [3:0] op, sa, sb, d;
    exp_dm.delete(); exp_alu.delete(); exp_fetch.delete();
    for (int i = 0; i < 16; i++) mdmem[i] = dmem_init[i];
    m_cycles = 0; m_err_ill = 1'b0; m_err_div0 = 1'b0;
    pc = 0; wrapped = 1'b0;
    for (int step = 0; step < 200; step++) begin
      exp_fetch.push_back(pc);
      ins = (patch_wrap && wrapped && pc == 0) ? 16'hF000 : imem[pc];
      op = ins[15:12]; sa = ins[11:8]; sb = ins[7:4]; d = ins[3:0];
      if (op == 4'hF) begin
        m_cycles += 2;
        break;
      end
      if (op == 4'h0) begin
        m_cycles += 2;
      end else if (op == 4'h3 || op == 4'h6 || op == 4'h7 || op == 4'h4) begin
        ia = int'(mdmem[sa]); ib = int'(mdmem[sb]);
        exp_dm.push_back({1'b0, sa, 8'h00});
        exp_dm.push_back({1'b0, sb, 8'h00});
        if (op == 4'h4 && ib == 0) begin
          m_err_div0 = 1'b1;
          m_cycles += 4;
        end else begin
          exp_alu.push_back({op, 8'(ia), 8'(ib)});
          r2 = 0;
          case (op)
            4'h3: r1 = (ia + ib) % 256;
            4'h6: r1 = (ia - ib + 256) % 256;
            4'h7: begin r1 = (ia * ib) % 256; r2 = (ia * ib) / 256; end
            default: begin r1 = ia / ib; r2 = ia % ib; end
          endcase
          mdmem[d] = 8'(r1);
          exp_dm.push_back({1'b1, d, 8'(r1)});
          if (op == 4'h7 || op == 4'h4) begin
            mdmem[(int'(d) + 1) % 16] = 8'(r2);
            exp_dm.push_back({1'b1, 4'((int'(d) + 1) % 16), 8'(r2)});
            m_cycles += 7;
          end else begin
            m_cycles += 6;
          end
        end
      end else begin
        m_err_ill = 1'b1;
        m_cycles += 2;
      end
      pc = (pc + 1) % IM_DEPTH;
      if (pc == 0) wrapped = 1'b1;
    end
  endtask

  task automatic loadData();
    load_req = 1'b1;
    waitCycle();
    load_req = 1'b0;
  endtask

  // Pulse start, follow the run to HALT and compare everything against the model
  task automatic applyStimulus(input bit patch_wrap, output int cycles);
    int n;
    runModel(patch_wrap);
    waitCycle();
    start = 1'b1;
    waitCycle();
    start = 1'b0;
    checkOutput("flags_cleared_ill", 32'(err_illegal), 32'd0);
    checkOutput("flags_cleared_div0", 32'(err_div0), 32'd0);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 1000) begin
      waitCycle();
      n++;
    end
    checkOutput("done_reached", 32'(done), 32'd1);
    cycles = n;
    checkOutput("cycles_to_done", 32'(n), 32'(m_cycles));
    checkOutput("err_illegal", 32'(err_illegal), 32'(m_err_ill));
    checkOutput("err_div0", 32'(err_div0), 32'(m_err_div0));
    checkOutput("pending_fetch", 32'(exp_fetch.size()), 32'd0);
    checkOutput("pending_dm", 32'(exp_dm.size()), 32'd0);
    checkOutput("pending_alu", 32'(exp_alu.size()), 32'd0);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("dmem[%0d]", i), 32'(dmem[i]), 32'(mdmem[i]));
  endtask

  task automatic clearProgram(input logic [15:0] fill);
    for (int i = 0; i < IM_DEPTH; i++) imem[i] = fill;
    for (int i = 0; i < 16; i++) dmem_init[i] = 8'h00;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, we0, alu0;
    bit seen;
    clearProgram(16'hF000);
    #2;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_errs", 32'({err_illegal, err_div0}), 32'd0);
    checkOutput("rst_strobes", 32'({im_re, dm_re, dm_we}), 32'd0);
    checkOutput("rst_alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);
    checkOutput("rst_im_addr", 32'(im_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    waitCycle();

    $display("[TB] ADD then HALT");
    clearProgram(16'hF000);
    imem[0] = 16'h3123; dmem_init[1] = 8'd20; dmem_init[2] = 8'd7;
    loadData();
    applyStimulus(1'b0, cyc);
    checkOutput("add_result", 32'(dmem[3]), 32'd27);
    checkOutput("add_halt_cycles", 32'(cyc), 32'd8);

    $display("[TB] MUL 200*3");
    clearProgram(16'hF000);
    imem[0] = 16'h7125; dmem_init[1] = 8'd200; dmem_init[2] = 8'd3;
    loadData();
    alu0 = alu_cycles;
    applyStimulus(1'b0, cyc);
    checkOutput("mul_lo", 32'(dmem[5]), 32'h58);
    checkOutput("mul_hi", 32'(dmem[6]), 32'h02);
    checkOutput("mul_alu_sel_cycles", 32'(alu_cycles - alu0), 32'd1);

    $display("[TB] DIV 23/5 and divide by zero");
    clearProgram(16'hF000);
    imem[0] = 16'h4123; dmem_init[1] = 8'd23; dmem_init[2] = 8'd5;
    loadData();
    applyStimulus(1'b0, cyc);
    checkOutput("div_quot", 32'(dmem[3]), 32'd4);
    checkOutput("div_rem", 32'(dmem[4]), 32'd3);
    clearProgram(16'hF000);
    imem[0] = 16'h4123; imem[1] = 16'h3117;
    dmem_init[1] = 8'd23; dmem_init[3] = 8'hAA;
    loadData();
    we0 = we_cycles;
    applyStimulus(1'b0, cyc);
    checkOutput("div0_flag", 32'(err_div0), 32'd1);
    checkOutput("div0_dest_untouched", 32'(dmem[3]), 32'hAA);
    checkOutput("div0_then_add", 32'(dmem[7]), 32'd46);
    checkOutput("div0_we_count", 32'(we_cycles - we0), 32'd1);
    checkOutput("div0_add_cycles", 32'(cyc), 32'd12);

    $display("[TB] illegal opcode, then re-run");
    clearProgram(16'hF000);
    imem[0] = 16'h9000;
    loadData();
    applyStimulus(1'b0, cyc);
    checkOutput("illegal_flag", 32'(err_illegal), 32'd1);
    checkOutput("illegal_cycles", 32'(cyc), 32'd4);
    applyStimulus(1'b0, cyc);
    checkOutput("illegal_flag_rerun", 32'(err_illegal), 32'd1);

    $display("[TB] address 15 cases");
    clearProgram(16'hF000);
    imem[0] = 16'h6FFF; dmem_init[15] = 8'd9;
    loadData();
    applyStimulus(1'b0, cyc);
    checkOutput("sub_self", 32'(dmem[15]), 32'd0);
    clearProgram(16'hF000);
    imem[0] = 16'h712F; dmem_init[1] = 8'd200; dmem_init[2] = 8'd3;
    loadData();
    applyStimulus(1'b0, cyc);
    checkOutput("mul_wrap_lo", 32'(dmem[15]), 32'h58);
    checkOutput("mul_wrap_hi", 32'(dmem[0]), 32'h02);

    $display("[TB] reset during WB1");
    clearProgram(16'hF000);
    imem[0] = 16'h3123; dmem_init[1] = 8'd20; dmem_init[2] = 8'd7; dmem_init[3] = 8'h11;
    loadData();
    runModel(1'b0);
    waitCycle();
    start = 1'b1;
    waitCycle();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = dm_we;
    end
    checkOutput("wb1_reached", 32'(seen), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_wb1_we", 32'(dm_we), 32'd0);
    checkOutput("rst_wb1_busy", 32'(busy), 32'd0);
    checkOutput("rst_wb1_bus", 32'({dm_addr, dm_wdata, dm_re}), 32'd0);
    checkOutput("rst_wb1_alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);
    exp_dm.delete(); exp_alu.delete(); exp_fetch.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) waitCycle();
    checkOutput("idle_after_reset", 32'({busy, done, im_re}), 32'd0);
    checkOutput("abandoned_write", 32'(dmem[3]), 32'h11);

    $display("[TB] PC wrap");
    clearProgram(16'h0000);
    loadData();
    fork
      applyStimulus(1'b1, cyc);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (im_re && im_addr == PC_W'(IM_DEPTH - 1)) begin
            imem[0] = 16'hF000;
            break;
          end
        end
      end
    join
    checkOutput("wrap_cycles", 32'(cyc), 32'd34);

    $display("[TB] randomized programs");
    for (int r = 0; r < 25; r++) begin
      int len;
      logic [3:0] op;
      clearProgram(16'hF000);
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) begin
        int k;
        k = int'($urandom_range(0, 10));
        op = (k < 9) ? op_tbl[k] : ill_tbl[$urandom_range(0, 9)];
        imem[i] = {op, 12'($urandom)};
      end
      for (int i = 0; i < 16; i++)
        dmem_init[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      loadData();
      applyStimulus(1'b0, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
